load_store_unit: RTL and testbench

Initiator side of the byte-addressed data memory interface: accepts one load or store request at a time from the execute stage, drives the memory's mem_read/mem_write/address/write_data lines, and returns a sign- or zero-extended load result. The memory always transfers 8 little-endian bytes starting at the given byte address. Sub-doubleword stores (sb/sh/sw) are therefore done as read-modify-write, so bytes outside the store width are preserved.

---
 rtl/load_store_unit_if.sv | 32 +++
 rtl/load_store_unit.sv | 150 +++++++++++++++
 tb/tb_load_store_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus bundle for load_store_unit.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// the requester holds its fields stable while req_valid is high and not yet accepted.
// resp_valid is a single-cycle pulse with no backpressure.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_error;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_read, mem_write, mem_address, mem_write_data
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           mem_read, mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for an 8-byte-wide, byte-addressed memory.
// Sub-doubleword stores are read-modify-write so untouched bytes are preserved.
module load_store_unit #(
  parameter int MEM_BYTES = 512
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus,
  output logic [2:0]         dbg_state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_STORE_RD = 3'd2;
  localparam logic [2:0] S_STORE_WR = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  logic [2:0]  state, state_nxt;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] data_q;
  logic        err_q;

  logic        accept;
  logic        req_err;
  logic [63:0] load_ext;
  logic [63:0] store_merge;

  assign accept    = bus.req_valid && bus.req_ready;
  assign dbg_state = state;

  // Stores only have widths 000..011; loads reject only 111.
  always_comb begin
    req_err = 1'b0;
    if (bus.req_write) req_err = bus.req_funct3[2];
    else               req_err = (bus.req_funct3 == 3'b111);
    if (bus.req_addr > MAX_ADDR) req_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                          state_nxt = S_RESP;
          else if (!bus.req_write)              state_nxt = S_LOAD;
          else if (bus.req_funct3[1:0] == 2'b11) state_nxt = S_STORE_WR;
          else                                  state_nxt = S_STORE_RD;
        end
      end
      S_LOAD:     state_nxt = S_RESP;
      S_STORE_RD: state_nxt = S_STORE_WR;
      S_STORE_WR: state_nxt = S_RESP;
      S_RESP:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load_ext = '0;
    case (funct3_q)
      3'b000: load_ext = {{56{bus.mem_read_data[7]}},  bus.mem_read_data[7:0]};
      3'b001: load_ext = {{48{bus.mem_read_data[15]}}, bus.mem_read_data[15:0]};
      3'b010: load_ext = {{32{bus.mem_read_data[31]}}, bus.mem_read_data[31:0]};
      3'b011: load_ext = bus.mem_read_data;
      3'b100: load_ext = {56'd0, bus.mem_read_data[7:0]};
      3'b101: load_ext = {48'd0, bus.mem_read_data[15:0]};
      3'b110: load_ext = {32'd0, bus.mem_read_data[31:0]};
      default: load_ext = '0;
    endcase
  end

  always_comb begin
    store_merge = wdata_q;
    case (funct3_q[1:0])
      2'b00:   store_merge = {bus.mem_read_data[63:8],  wdata_q[7:0]};
      2'b01:   store_merge = {bus.mem_read_data[63:16], wdata_q[15:0]};
      2'b10:   store_merge = {bus.mem_read_data[63:32], wdata_q[31:0]};
      default: store_merge = wdata_q;
    endcase
  end

  // data_q starts as the raw store data (used directly by sd), then holds
  // either the merged RMW word or the extended load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            write_q  <= bus.req_write;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            data_q   <= bus.req_wdata;
            err_q    <= req_err;
          end
        end
        S_LOAD:     data_q <= load_ext;
        S_STORE_RD: data_q <= store_merge;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.resp_rdata     = '0;
    bus.resp_error     = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_address    = '0;
    bus.mem_write_data = '0;
    case (state)
      S_IDLE: bus.req_ready = !reset;
      S_LOAD, S_STORE_RD: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = addr_q;
      end
      S_STORE_WR: begin
        bus.mem_write      = !reset;
        bus.mem_address    = addr_q;
        bus.mem_write_data = data_q;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_error = err_q;
        bus.resp_rdata = (!write_q && !err_q) ? data_q : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus hand-written
// back-to-back and mid-transaction reset sequences, against a byte memory model.
module tb_load_store_unit;
  localparam int MEM_BYTES = 512;
  localparam int NV = 23;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // ---- memory model ----
  logic [7:0] mem [MEM_BYTES];

  always_comb begin
    bus.mem_read_data = '0;
    if (bus.mem_address <= 64'(MEM_BYTES - 8))
      for (int k = 0; k < 8; k++)
        bus.mem_read_data[8*k +: 8] = mem[int'(bus.mem_address) + k];
  end

  always @(posedge clk) begin
    if (bus.mem_write && bus.mem_address <= 64'(MEM_BYTES - 8))
      for (int k = 0; k < 8; k++)
        mem[int'(bus.mem_address) + k] <= bus.mem_write_data[8*k +: 8];
  end

  // ---- scoreboard ----
  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          n_rd;
    int          n_wr;
  } vec_t;

  vec_t        vecs [NV];
  logic [63:0] exp_q [$];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---- driver ----
  task automatic drive_req(input vec_t v);
    bus.req_write  = v.wr;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.req_valid  = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n, lat, n_rd, n_wr, busy_ready;
    logic [63:0] got_rdata, exp_rdata;
    logic        got_err;
    exp_q.push_back(v.rdata);
    @(negedge clk);
    drive_req(v);
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d accept", idx), 64'(n < 20), 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0; n_rd = 0; n_wr = 0; busy_ready = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.mem_read)  n_rd++;
      if (bus.mem_write) n_wr++;
      if (bus.req_ready) busy_ready++;
    end while (!bus.resp_valid && lat < 20);
    got_rdata = bus.resp_rdata;
    got_err   = bus.resp_error;
    exp_rdata = exp_q.pop_front();
    check($sformatf("v%0d latency", idx),    64'(lat),        64'(v.lat));
    check($sformatf("v%0d rdata", idx),      got_rdata,       exp_rdata);
    check($sformatf("v%0d error", idx),      64'(got_err),    64'(v.err));
    check($sformatf("v%0d mem_read", idx),   64'(n_rd),       64'(v.n_rd));
    check($sformatf("v%0d mem_write", idx),  64'(n_wr),       64'(v.n_wr));
    check($sformatf("v%0d busy_ready", idx), 64'(busy_ready), 64'd0);
    @(negedge clk);
    check($sformatf("v%0d post_rdata", idx), bus.resp_rdata, 64'd0);
    check($sformatf("v%0d post_valid", idx), {62'd0, bus.resp_valid, bus.resp_error}, 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req_ready"},  64'(bus.req_ready),  64'd0);
    check({tag, " resp"},       {62'd0, bus.resp_valid, bus.resp_error}, 64'd0);
    check({tag, " resp_rdata"}, bus.resp_rdata,      64'd0);
    check({tag, " mem_rw"},     {62'd0, bus.mem_read, bus.mem_write}, 64'd0);
    check({tag, " mem_addr"},   bus.mem_address,     64'd0);
    check({tag, " mem_wdata"},  bus.mem_write_data,  64'd0);
    check({tag, " state"},      64'(dbg_state),      64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tmp;
    int   rdy_exp [5];
    int   rv_exp  [5];
    int   cnt;

    //         wr    f3    addr                    wdata                    rdata                    err  lat rd wr
    vecs[0]  = '{1'b1, 3'd3, 64'd16,  64'h8877_6655_4433_2211, 64'h0,                    1'b0, 2, 0, 1};
    vecs[1]  = '{1'b0, 3'd3, 64'd16,  64'h0,                   64'h8877_6655_4433_2211, 1'b0, 2, 1, 0};
    vecs[2]  = '{1'b1, 3'd0, 64'd17,  64'hAB,                  64'h0,                    1'b0, 3, 1, 1};
    vecs[3]  = '{1'b0, 3'd3, 64'd16,  64'h0,                   64'h8877_6655_4433_AB11, 1'b0, 2, 1, 0};
    vecs[4]  = '{1'b1, 3'd3, 64'd40,  64'h0000_0000_8000_80F0, 64'h0,                    1'b0, 2, 0, 1};
    vecs[5]  = '{1'b0, 3'd0, 64'd40,  64'h0,                   64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 2, 1, 0};
    vecs[6]  = '{1'b0, 3'd4, 64'd40,  64'h0,                   64'h0000_0000_0000_00F0, 1'b0, 2, 1, 0};
    vecs[7]  = '{1'b0, 3'd1, 64'd40,  64'h0,                   64'hFFFF_FFFF_FFFF_80F0, 1'b0, 2, 1, 0};
    vecs[8]  = '{1'b0, 3'd5, 64'd40,  64'h0,                   64'h0000_0000_0000_80F0, 1'b0, 2, 1, 0};
    vecs[9]  = '{1'b0, 3'd6, 64'd40,  64'h0,                   64'h0000_0000_8000_80F0, 1'b0, 2, 1, 0};
    vecs[10] = '{1'b0, 3'd2, 64'd40,  64'h0,                   64'hFFFF_FFFF_8000_80F0, 1'b0, 2, 1, 0};
    vecs[11] = '{1'b0, 3'd3, 64'd505, 64'h0,                   64'h0,                    1'b1, 1, 0, 0};
    vecs[12] = '{1'b1, 3'd3, 64'd504, 64'h0123_4567_89AB_CDEF, 64'h0,                    1'b0, 2, 0, 1};
    vecs[13] = '{1'b0, 3'd3, 64'd504, 64'h0,                   64'h0123_4567_89AB_CDEF, 1'b0, 2, 1, 0};
    vecs[14] = '{1'b0, 3'd7, 64'd0,   64'h0,                   64'h0,                    1'b1, 1, 0, 0};
    vecs[15] = '{1'b1, 3'd4, 64'd0,   64'hFFFF,                64'h0,                    1'b1, 1, 0, 0};
    vecs[16] = '{1'b0, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,   64'h0,                    1'b1, 1, 0, 0};
    vecs[17] = '{1'b1, 3'd1, 64'd18,  64'hFFFF_CAFE,           64'h0,                    1'b0, 3, 1, 1};
    vecs[18] = '{1'b0, 3'd3, 64'd16,  64'h0,                   64'h8877_6655_CAFE_AB11, 1'b0, 2, 1, 0};
    vecs[19] = '{1'b1, 3'd2, 64'd20,  64'h1234_5678_9ABC_DEF0, 64'h0,                    1'b0, 3, 1, 1};
    vecs[20] = '{1'b0, 3'd3, 64'd16,  64'h0,                   64'h9ABC_DEF0_CAFE_AB11, 1'b0, 2, 1, 0};
    vecs[21] = '{1'b1, 3'd3, 64'd24,  64'h1111_2222_3333_4444, 64'h0,                    1'b0, 2, 0, 1};
    vecs[22] = '{1'b0, 3'd3, 64'd0,   64'h0,                   64'h0,                    1'b0, 2, 1, 0};

    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;

    // ---- clock/reset ----
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check("ready after reset", 64'(bus.req_ready), 64'd1);

    // ---- vector table ----
    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // ---- back-to-back loads with req_valid held high ----
    rdy_exp = '{0, 0, 1, 0, 0};
    rv_exp  = '{0, 1, 0, 0, 1};
    @(negedge clk);
    tmp = '{1'b0, 3'd3, 64'd16, 64'h0, 64'h0, 1'b0, 0, 0, 0};
    drive_req(tmp);
    check("b2b first ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1 bus.req_addr = 64'd40;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("b2b c%0d ready", i), 64'(bus.req_ready), 64'(rdy_exp[i]));
      check($sformatf("b2b c%0d valid", i), 64'(bus.resp_valid), 64'(rv_exp[i]));
      if (i == 1) check("b2b rdata0", bus.resp_rdata, 64'h9ABC_DEF0_CAFE_AB11);
      if (i == 4) check("b2b rdata1", bus.resp_rdata, 64'h0000_0000_8000_80F0);
      if (i == 2) begin
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
      end
    end

    // ---- reset during STORE_RD of sw ----
    @(negedge clk);
    tmp = '{1'b1, 3'd2, 64'd24, 64'h5555_5555, 64'h0, 1'b0, 0, 0, 0};
    drive_req(tmp);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_rd in STORE_RD", {61'd0, dbg_state}, 64'd2);
    check("rst_rd mem_read", 64'(bus.mem_read), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("rst_rd");
    reset = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.mem_write || bus.resp_valid) cnt++;
    end
    check("rst_rd no activity", 64'(cnt), 64'd0);
    tmp = '{1'b0, 3'd3, 64'd24, 64'h0, 64'h1111_2222_3333_4444, 1'b0, 2, 1, 0};
    run_vec(100, tmp);

    // ---- reset during STORE_WR of sd ----
    @(negedge clk);
    tmp = '{1'b1, 3'd3, 64'd32, 64'hDEAD_BEEF, 64'h0, 1'b0, 0, 0, 0};
    drive_req(tmp);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_wr mem_write before", 64'(bus.mem_write), 64'd1);
    reset = 1'b1;
    #1;
    check("rst_wr mem_write gated", 64'(bus.mem_write), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.mem_write || bus.resp_valid) cnt++;
    end
    check("rst_wr no activity", 64'(cnt), 64'd0);
    tmp = '{1'b0, 3'd3, 64'd32, 64'h0, 64'h0, 1'b0, 2, 1, 0};
    run_vec(101, tmp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
